// File: rtl/bcd_calendar_counter_pkg.sv
// Shared definitions for the century-clock date path: BCD types, month constants,
// weekday encoding and BCD arithmetic helpers.
package bcd_calendar_counter_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd_byte_t;

  localparam bcd_byte_t MON_JAN = 8'h01;
  localparam bcd_byte_t MON_FEB = 8'h02;
  localparam bcd_byte_t MON_MAR = 8'h03;
  localparam bcd_byte_t MON_APR = 8'h04;
  localparam bcd_byte_t MON_MAY = 8'h05;
  localparam bcd_byte_t MON_JUN = 8'h06;
  localparam bcd_byte_t MON_JUL = 8'h07;
  localparam bcd_byte_t MON_AUG = 8'h08;
  localparam bcd_byte_t MON_SEP = 8'h09;
  localparam bcd_byte_t MON_OCT = 8'h10;
  localparam bcd_byte_t MON_NOV = 8'h11;
  localparam bcd_byte_t MON_DEC = 8'h12;

  typedef enum logic [2:0] {
    WD_MON = 3'd0,
    WD_TUE = 3'd1,
    WD_WED = 3'd2,
    WD_THU = 3'd3,
    WD_FRI = 3'd4,
    WD_SAT = 3'd5,
    WD_SUN = 3'd6
  } wday_e;

  typedef struct packed {
    logic      carry;
    bcd_byte_t value;
  } bcd_inc_t;

  // Two-digit BCD increment; 99 wraps to 00 with carry set.
  function automatic bcd_inc_t bcd_inc8(input bcd_byte_t v);
    bcd_inc_t   r;
    bcd_digit_t ones;
    bcd_digit_t tens;
    ones    = v[3:0];
    tens    = v[7:4];
    r.carry = 1'b0;
    if (ones >= 4'd9) begin
      ones = 4'd0;
      if (tens >= 4'd9) begin
        tens    = 4'd0;
        r.carry = 1'b1;
      end else begin
        tens = tens + 4'd1;
      end
    end else begin
      ones = ones + 4'd1;
    end
    r.value = {tens, ones};
    return r;
  endfunction

  function automatic logic bcd_byte_ok(input bcd_byte_t v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_calendar_counter_month_length.sv
// Combinational month-length and leap-year decode for a BCD month/year pair.
// An out-of-range month yields a length of 00 so no day can be valid against it.
module bcd_month_length
  import bcd_calendar_counter_pkg::*;
(
  input  bcd_byte_t month_bcd,
  input  bcd_byte_t year_bcd,
  output bcd_byte_t days_in_month,
  output logic      leap
);

  bcd_digit_t tens;
  bcd_digit_t ones;

  assign tens = year_bcd[7:4];
  assign ones = year_bcd[3:0];

  // Divisibility by 4 decided on the decimal digits: 10*T+U is a multiple of 4
  // exactly when U is 0/4/8 with T even, or 2/6 with T odd.
  always_comb begin
    if (!tens[0]) begin
      leap = (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
    end else begin
      leap = (ones == 4'd2) || (ones == 4'd6);
    end
  end

  always_comb begin
    days_in_month = 8'h00;
    case (month_bcd)
      MON_JAN, MON_MAR, MON_MAY, MON_JUL,
      MON_AUG, MON_OCT, MON_DEC:          days_in_month = 8'h31;
      MON_APR, MON_JUN, MON_SEP, MON_NOV: days_in_month = 8'h30;
      MON_FEB:                            days_in_month = leap ? 8'h29 : 8'h28;
      default:                            days_in_month = 8'h00;
    endcase
  end

endmodule

// File: rtl/bcd_calendar_counter.sv
// BCD day/month/year and weekday register set, advanced by day_tick and
// loadable with a validated date. Pulses century_tick on 99 -> 00 rollover.
module bcd_calendar_counter
  import bcd_calendar_counter_pkg::*;
#(
  parameter logic [7:0] RESET_DAY   = 8'h01,
  parameter logic [7:0] RESET_MONTH = 8'h01,
  parameter logic [7:0] RESET_YEAR  = 8'h00,
  parameter logic [2:0] RESET_WDAY  = 3'd6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       day_tick,
  input  logic       load,
  input  logic [7:0] load_day,
  input  logic [7:0] load_month,
  input  logic [7:0] load_year,
  input  logic [2:0] load_wday,
  output logic [7:0] day_bcd,
  output logic [7:0] month_bcd,
  output logic [7:0] year_bcd,
  output logic [2:0] wday,
  output logic       leap_year,
  output logic       century_tick,
  output logic       load_err
);

  bcd_byte_t  day_q;
  bcd_byte_t  month_q;
  bcd_byte_t  year_q;
  logic [2:0] wday_q;
  logic       century_q;
  logic       err_q;

  bcd_byte_t  cur_dim;
  logic       cur_leap;
  bcd_byte_t  load_dim;
  logic       load_leap_unused;

  bcd_inc_t   day_inc;
  bcd_inc_t   month_inc;
  bcd_inc_t   year_inc;
  logic       day_wrap;
  logic       month_wrap;
  bcd_byte_t  day_next;
  bcd_byte_t  month_next;
  bcd_byte_t  year_next;
  logic [2:0] wday_next;
  logic       century_next;
  logic       load_ok;

  bcd_month_length u_cur_len (
    .month_bcd     (month_q),
    .year_bcd      (year_q),
    .days_in_month (cur_dim),
    .leap          (cur_leap)
  );

  bcd_month_length u_load_len (
    .month_bcd     (load_month),
    .year_bcd      (load_year),
    .days_in_month (load_dim),
    .leap          (load_leap_unused)
  );

  // Next date for a tick. ">=" on the day compare also recovers from any
  // day beyond the month length by wrapping to the 1st.
  always_comb begin
    day_inc      = bcd_inc8(day_q);
    month_inc    = bcd_inc8(month_q);
    year_inc     = bcd_inc8(year_q);
    day_wrap     = (day_q >= cur_dim) | day_inc.carry;
    month_wrap   = (month_q == MON_DEC) | month_inc.carry;
    day_next     = day_inc.value;
    month_next   = month_q;
    year_next    = year_q;
    century_next = 1'b0;
    if (day_wrap) begin
      day_next = 8'h01;
      if (month_wrap) begin
        month_next   = MON_JAN;
        year_next    = year_inc.value;
        century_next = year_inc.carry;
      end else begin
        month_next = month_inc.value;
      end
    end
    wday_next = (wday_q >= 3'(WD_SUN)) ? 3'd0 : wday_q + 3'd1;
  end

  // BCD bytes compare correctly as plain binary once each nibble is <= 9.
  always_comb begin
    load_ok = bcd_byte_ok(load_day) && bcd_byte_ok(load_month) && bcd_byte_ok(load_year)
              && (load_month >= MON_JAN) && (load_month <= MON_DEC)
              && (load_day >= 8'h01) && (load_day <= load_dim)
              && (load_wday <= 3'(WD_SUN));
  end

  // A load always wins over a simultaneous tick, whether or not it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_q     <= RESET_DAY;
      month_q   <= RESET_MONTH;
      year_q    <= RESET_YEAR;
      wday_q    <= RESET_WDAY;
      century_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      century_q <= 1'b0;
      err_q     <= 1'b0;
      if (load) begin
        if (load_ok) begin
          day_q   <= load_day;
          month_q <= load_month;
          year_q  <= load_year;
          wday_q  <= load_wday;
        end else begin
          err_q <= 1'b1;
        end
      end else if (day_tick) begin
        day_q     <= day_next;
        month_q   <= month_next;
        year_q    <= year_next;
        wday_q    <= wday_next;
        century_q <= century_next;
      end
    end
  end

  assign day_bcd      = day_q;
  assign month_bcd    = month_q;
  assign year_bcd     = year_q;
  assign wday         = wday_q;
  assign leap_year    = cur_leap;
  assign century_tick = century_q;
  assign load_err     = err_q;

endmodule

// File: tb/tb_bcd_calendar_counter.sv
// Directed bench for bcd_calendar_counter: an integer calendar model feeds an
// expected-value queue that is checked one cycle after each driven step.
module tb_bcd_calendar_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       day_tick;
  logic       load;
  logic [7:0] load_day;
  logic [7:0] load_month;
  logic [7:0] load_year;
  logic [2:0] load_wday;
  logic [7:0] day_bcd;
  logic [7:0] month_bcd;
  logic [7:0] year_bcd;
  logic [2:0] wday;
  logic       leap_year;
  logic       century_tick;
  logic       load_err;

  int total = 0;
  int bad   = 0;

  // {day, month, year, wday, leap, century, err}
  logic [29:0] exp_q[$];

  int m_day;
  int m_mon;
  int m_year;
  int m_wday;
  bit m_cent;
  bit m_err;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  bcd_calendar_counter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .day_tick     (day_tick),
    .load         (load),
    .load_day     (load_day),
    .load_month   (load_month),
    .load_year    (load_year),
    .load_wday    (load_wday),
    .day_bcd      (day_bcd),
    .month_bcd    (month_bcd),
    .year_bcd     (year_bcd),
    .wday         (wday),
    .leap_year    (leap_year),
    .century_tick (century_tick),
    .load_err     (load_err)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit is_leap(input int y);
    return (y % 4) == 0;
  endfunction

  function automatic int dim_of(input int m, input int y);
    case (m)
      2:           return is_leap(y) ? 29 : 28;
      4, 6, 9, 11: return 30;
      default:     return 31;
    endcase
  endfunction

  function automatic bit nib_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic logic [29:0] model_word();
    return {to_bcd(m_day), to_bcd(m_mon), to_bcd(m_year), 3'(m_wday),
            is_leap(m_year), m_cent, m_err};
  endfunction

  function automatic string fmt(input logic [29:0] w);
    return $sformatf("%h-%h-%h wday=%0d leap=%b cent=%b err=%b",
                     w[29:22], w[21:14], w[13:6], w[5:3], w[2], w[1], w[0]);
  endfunction

  task automatic model_reset();
    m_day  = 1;
    m_mon  = 1;
    m_year = 0;
    m_wday = 6;
    m_cent = 0;
    m_err  = 0;
  endtask

  task automatic model_apply(input bit tk, input bit ld, input logic [7:0] d,
                             input logic [7:0] mo, input logic [7:0] y,
                             input logic [2:0] w);
    int di, mi, yi;
    bit ok;
    m_cent = 0;
    m_err  = 0;
    if (ld) begin
      ok = nib_ok(d) && nib_ok(mo) && nib_ok(y);
      di = from_bcd(d);
      mi = from_bcd(mo);
      yi = from_bcd(y);
      if (ok) ok = (mi >= 1) && (mi <= 12);
      if (ok) ok = (di >= 1) && (di <= dim_of(mi, yi)) && (w <= 3'd6);
      if (ok) begin
        m_day  = di;
        m_mon  = mi;
        m_year = yi;
        m_wday = int'(w);
      end else begin
        m_err = 1;
      end
    end else if (tk) begin
      m_wday = (m_wday + 1) % 7;
      if (m_day < dim_of(m_mon, m_year)) begin
        m_day = m_day + 1;
      end else begin
        m_day = 1;
        if (m_mon == 12) begin
          m_mon = 1;
          if (m_year == 99) begin
            m_year = 0;
            m_cent = 1;
          end else begin
            m_year = m_year + 1;
          end
        end else begin
          m_mon = m_mon + 1;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag);
    logic [29:0] obs;
    logic [29:0] exp;
    obs = {day_bcd, month_bcd, year_bcd, wday, leap_year, century_tick, load_err};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: no expected entry, observed %s", tag, fmt(obs));
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        bad++;
        $error("FAIL %s: observed %s expected %s", tag, fmt(obs), fmt(exp));
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input bit tk, input bit ld,
                      input logic [7:0] d, input logic [7:0] mo,
                      input logic [7:0] y, input logic [2:0] w);
    day_tick   = tk;
    load       = ld;
    load_day   = d;
    load_month = mo;
    load_year  = y;
    load_wday  = w;
    model_apply(tk, ld, d, mo, y, w);
    exp_q.push_back(model_word());
    @(posedge clk);
    #1;
    day_tick = 1'b0;
    load     = 1'b0;
    check(tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n      = 1'b0;
    day_tick   = 1'b0;
    load       = 1'b0;
    load_day   = 8'h00;
    load_month = 8'h00;
    load_year  = 8'h00;
    load_wday  = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    exp_q.push_back(model_word());
    check("reset_values");
    rst_n = 1'b1;
    step("post_reset_idle", 0, 0, 8'h00, 8'h00, 8'h00, 3'd0);

    // Non-leap February end
    step("ld_28_02_23", 0, 1, 8'h28, 8'h02, 8'h23, 3'd1);
    step("tick_01_03_23", 1, 0, 8'h00, 8'h00, 8'h00, 3'd0);

    // Leap February
    step("ld_28_02_24", 0, 1, 8'h28, 8'h02, 8'h24, 3'd3);
    step("tick_29_02_24", 1, 0, 8'h00, 8'h00, 8'h00, 3'd0);
    step("tick_01_03_24", 1, 0, 8'h00, 8'h00, 8'h00, 3'd0);

    // Century rollover and the single-cycle pulse
    step("ld_31_12_99", 0, 1, 8'h31, 8'h12, 8'h99, 3'd6);
    step("tick_century", 1, 0, 8'h00, 8'h00, 8'h00, 3'd0);
    step("century_clears", 0, 0, 8'h00, 8'h00, 8'h00, 3'd0);

    // Rejected loads
    step("bad_30_02_24", 0, 1, 8'h30, 8'h02, 8'h24, 3'd2);
    step("err_clears", 0, 0, 8'h00, 8'h00, 8'h00, 3'd0);
    step("bad_month_1a", 0, 1, 8'h15, 8'h1A, 8'h24, 3'd2);
    step("bad_12_13_05", 0, 1, 8'h12, 8'h13, 8'h05, 3'd2);
    step("bad_month_00", 0, 1, 8'h10, 8'h00, 8'h05, 3'd2);
    step("bad_day_00", 0, 1, 8'h00, 8'h05, 8'h05, 3'd2);
    step("bad_day_1a", 0, 1, 8'h1A, 8'h05, 8'h05, 3'd2);
    step("bad_year_a5", 0, 1, 8'h10, 8'h05, 8'hA5, 3'd2);
    step("bad_wday_7", 0, 1, 8'h10, 8'h05, 8'h05, 3'd7);
    step("bad_29_02_23", 0, 1, 8'h29, 8'h02, 8'h23, 3'd2);
    step("bad_31_04_24", 0, 1, 8'h31, 8'h04, 8'h24, 3'd2);

    // Load beats tick; invalid load with tick also drops the tick
    step("ld_tick_15_06_50", 1, 1, 8'h15, 8'h06, 8'h50, 3'd4);
    step("bad_ld_tick", 1, 1, 8'h32, 8'h01, 8'h10, 3'd1);
    step("ld_year_12", 0, 1, 8'h01, 8'h01, 8'h12, 3'd0);
    step("ld_year_10", 0, 1, 8'h01, 8'h01, 8'h10, 3'd0);
    step("ld_year_96", 0, 1, 8'h09, 8'h01, 8'h96, 3'd0);
    step("tick_09_to_10", 1, 0, 8'h00, 8'h00, 8'h00, 3'd0);

    // Long tick run across a century boundary with a reset in the middle
    step("ld_25_12_98", 0, 1, 8'h25, 8'h12, 8'h98, 3'd4);
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        day_tick = 1'b1;
        rst_n    = 1'b0;
        #1;
        model_reset();
        exp_q.push_back(model_word());
        check("midrun_reset");
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        day_tick = 1'b0;
      end
      step("run_tick", 1, 0, 8'h00, 8'h00, 8'h00, 3'd0);
    end

    // Every month of every year: last day accepted, next day rejected, tick wraps
    for (int y = 0; y < 100; y++) begin
      for (int m = 1; m <= 12; m++) begin
        int d;
        logic [2:0] w;
        d = dim_of(m, y);
        w = 3'($urandom_range(0, 6));
        step($sformatf("mlen_last_%0d_%0d", m, y), 0, 1, to_bcd(d), to_bcd(m), to_bcd(y), w);
        step($sformatf("mlen_over_%0d_%0d", m, y), 0, 1, to_bcd(d + 1), to_bcd(m), to_bcd(y), w);
        step($sformatf("mlen_wrap_%0d_%0d", m, y), 1, 0, 8'h00, 8'h00, 8'h00, 3'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
